// File: rtl/bram_readout_engine_pkg.sv
// Shared types and helpers for the BRAM readout engine: FSM encoding,
// sign extension and a minimum-one-bit width helper.
package bram_readout_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Replicates bit w-1 of d into every bit above it.
  function automatic logic [63:0] sign_extend(input logic [63:0] d, input int unsigned w);
    logic [63:0] r;
    r = d;
    for (int i = 0; i < 64; i++) begin
      if (i >= int'(w)) r[i] = d[w-1];
    end
    return r;
  endfunction

  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bram_readout_engine_skid_fifo.sv
// readout_skid_fifo: small synchronous FIFO with flush; holds {last, index, data}
// words between the BRAM capture stage and the output stream.
module readout_skid_fifo
  import bram_readout_engine_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          push,
  input  logic [W-1:0]                  push_data,
  input  logic                          pop,
  output logic [W-1:0]                  rd_data,
  output logic                          rd_valid,
  output logic [width_of(DEPTH+1)-1:0]  count
);

  localparam int PTR_W = width_of(DEPTH);
  localparam int CNT_W = width_of(DEPTH+1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    do_pop  = pop && (cnt_q != '0);
    do_push = push && ((cnt_q != CNT_W'(DEPTH)) || do_pop);
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = push_data;
        wr_d = (wr_q == PTR_W'(DEPTH-1)) ? '0 : wr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_d = (rd_q == PTR_W'(DEPTH-1)) ? '0 : rd_q + PTR_W'(1);
      end
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no control meaning, so it is left out of reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data  = mem_q[rd_q];
  assign rd_valid = (cnt_q != '0);
  assign count    = cnt_q;

endmodule

// File: rtl/bram_readout_engine.sv
// Sweeps all FFT2D result BRAM banks over port A and streams each sign-extended
// word with its running index. Optional peak tracker under READOUT_PEAK_EN.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | issuing reads row/bank/element order, gated by FIFO credit
// DRAIN | last read issued, waiting for FIFO and pipeline to empty
// DONE  | one-cycle done pulse
module bram_readout_engine
  import bram_readout_engine_pkg::*;
#(
  parameter int NUM_BANKS = 32,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 9,
  parameter int BASE_ADDR = 256,
  parameter int ROWS      = 2,
  parameter int ELEMS     = 128,
  parameter int OUT_W     = 32,
  parameter int RD_LAT    = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [NUM_BANKS*ADDR_W-1:0] bram_addra,
  output logic [NUM_BANKS-1:0]        bram_rea,
  output logic [NUM_BANKS-1:0]        bram_wea,
  input  logic [NUM_BANKS*DATA_W-1:0] bram_dataa,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_W-1:0]            out_data,
  output logic [31:0]                 out_index,
  output logic                        out_last
`ifdef READOUT_PEAK_EN
  ,
  output logic [DATA_W-1:0]           peak_abs
`endif
);

  localparam int DEPTH  = RD_LAT + 2;
  localparam int TOTAL  = NUM_BANKS * ROWS * ELEMS;
  localparam int K_W    = width_of(ELEMS);
  localparam int B_W    = width_of(NUM_BANKS);
  localparam int R_W    = width_of(ROWS);
  localparam int CNT_W  = width_of(DEPTH + 1);
  localparam int FIFO_W = 1 + 32 + OUT_W;

  state_e            state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [B_W-1:0]    b_q, b_d;
  logic [R_W-1:0]    r_q, r_d;
  logic [31:0]       push_idx_q, push_idx_d;
  logic [RD_LAT-1:0] vld_pipe_q, vld_pipe_d;
  logic [B_W-1:0]    bank_pipe_q [RD_LAT];
  logic [B_W-1:0]    bank_pipe_d [RD_LAT];

  logic              issue, start_acc, last_issue, push, pop;
  int                inflight;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] cap_word;
  logic [FIFO_W-1:0] push_data, fifo_rd;
  logic              fifo_valid;
  logic [CNT_W-1:0]  fifo_count;

  assign pop        = fifo_valid && out_ready;
  assign push       = vld_pipe_q[RD_LAT-1];
  assign last_issue = (k_q == K_W'(ELEMS-1)) && (b_q == B_W'(NUM_BANKS-1)) &&
                      (r_q == R_W'(ROWS-1));

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    b_d        = b_q;
    r_d        = r_q;
    push_idx_d = push_idx_q;
    issue      = 1'b0;
    start_acc  = 1'b0;
    inflight   = 0;
    for (int i = 0; i < RD_LAT; i++) inflight += int'(vld_pipe_q[i]);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_acc  = 1'b1;
          state_d    = ST_ISSUE;
          k_d        = '0;
          b_d        = '0;
          r_d        = '0;
          push_idx_d = '0;
        end
      end
      ST_ISSUE: begin
        // Credit check keeps every in-flight read guaranteed a FIFO slot.
        if (int'(fifo_count) + inflight < DEPTH) begin
          issue = 1'b1;
          if (k_q == K_W'(ELEMS-1)) begin
            k_d = '0;
            if (b_q == B_W'(NUM_BANKS-1)) begin
              b_d = '0;
              r_d = (r_q == R_W'(ROWS-1)) ? '0 : r_q + R_W'(1);
            end else begin
              b_d = b_q + B_W'(1);
            end
          end else begin
            k_d = k_q + K_W'(1);
          end
          if (last_issue) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave on the cycle of the final transfer so done trails it by one.
        if (inflight == 0 &&
            (fifo_count == '0 || (fifo_count == CNT_W'(1) && pop)))
          state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (push) push_idx_d = push_idx_q + 32'd1;

    vld_pipe_d     = vld_pipe_q;
    bank_pipe_d    = bank_pipe_q;
    vld_pipe_d[0]  = issue;
    bank_pipe_d[0] = b_q;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_pipe_d[i]  = vld_pipe_q[i-1];
      bank_pipe_d[i] = bank_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      b_q        <= '0;
      r_q        <= '0;
      push_idx_q <= '0;
      vld_pipe_q <= '0;
      for (int i = 0; i < RD_LAT; i++) bank_pipe_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      b_q         <= b_d;
      r_q         <= r_d;
      push_idx_q  <= push_idx_d;
      vld_pipe_q  <= vld_pipe_d;
      bank_pipe_q <= bank_pipe_d;
    end
  end

  assign rd_addr = ADDR_W'(BASE_ADDR + int'(r_q) * ELEMS + int'(k_q));

  always_comb begin
    bram_addra = '0;
    bram_rea   = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (issue && (b_q == B_W'(b))) begin
        bram_addra[b*ADDR_W +: ADDR_W] = rd_addr;
        bram_rea[b]                    = 1'b1;
      end
    end
  end

  assign bram_wea  = '0;
  assign cap_word  = bram_dataa[int'(bank_pipe_q[RD_LAT-1])*DATA_W +: DATA_W];
  assign push_data = {(push_idx_q == 32'(TOTAL-1)), push_idx_q,
                      OUT_W'(sign_extend(64'(cap_word), DATA_W))};

  readout_skid_fifo #(
    .W     (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (start_acc),
    .push      (push),
    .push_data (push_data),
    .pop       (out_ready),
    .rd_data   (fifo_rd),
    .rd_valid  (fifo_valid),
    .count     (fifo_count)
  );

  assign out_valid = fifo_valid;
  assign out_data  = fifo_rd[OUT_W-1:0];
  assign out_index = fifo_rd[OUT_W +: 32];
  assign out_last  = fifo_rd[FIFO_W-1];
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

`ifdef READOUT_PEAK_EN
  logic [DATA_W-1:0] peak_q, peak_d, xfer_abs, xfer_raw;

  assign xfer_raw = fifo_rd[DATA_W-1:0];

  always_comb begin
    // Most negative value has no positive twin; clamp to max positive.
    if (!xfer_raw[DATA_W-1])
      xfer_abs = xfer_raw;
    else if (xfer_raw == {1'b1, {(DATA_W-1){1'b0}}})
      xfer_abs = {1'b0, {(DATA_W-1){1'b1}}};
    else
      xfer_abs = -xfer_raw;

    peak_d = peak_q;
    if (start_acc)
      peak_d = '0;
    else if (pop && (xfer_abs > peak_q))
      peak_d = xfer_abs;
  end

  always_ff @(posedge clk) begin
    if (reset) peak_q <= '0;
    else       peak_q <= peak_d;
  end

  assign peak_abs = peak_q;
`endif

endmodule

// File: tb/tb_bram_readout_engine.sv
// Directed bench for bram_readout_engine: BRAM model, stream monitor,
// table of hand-computed words, and sequences for stall, reset and restart.
module tb_bram_readout_engine;

  localparam int NB    = 32;
  localparam int DW    = 16;
  localparam int AW    = 9;
  localparam int TOTAL = 8192;

  logic              clk = 1'b0;
  logic              reset, start, out_ready;
  logic              busy, done, out_valid, out_last;
  logic [NB*AW-1:0]  bram_addra;
  logic [NB-1:0]     bram_rea, bram_wea;
  logic [NB*DW-1:0]  bram_dataa;
  logic [31:0]       out_data, out_index;
`ifdef READOUT_PEAK_EN
  logic [DW-1:0]     peak_abs;
`endif

  always #5 clk = ~clk;

  bram_readout_engine dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .bram_addra (bram_addra),
    .bram_rea   (bram_rea),
    .bram_wea   (bram_wea),
    .bram_dataa (bram_dataa),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_last   (out_last)
`ifdef READOUT_PEAK_EN
    ,
    .peak_abs   (peak_abs)
`endif
  );

  logic [DW-1:0] mem [NB][512];

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      if (bram_rea[b]) bram_dataa[b*DW +: DW] <= mem[b][bram_addra[b*AW +: AW]];
  end

  function automatic logic [31:0] exp_word(input int i);
    int r, b, k;
    logic [DW-1:0] w;
    r = i / (NB * 128);
    b = (i / 128) % NB;
    k = i % 128;
    w = mem[b][256 + r * 128 + k];
    return {{16{w[15]}}, w};
  endfunction

  // Stream monitor
  logic        mon_clear = 1'b1;
  int          cyc = 0, xfer_cnt, word_err, stall_err, stall_seen, done_cnt, done_late, last_cyc;
  logic        held_valid;
  logic [31:0] held_data, held_index;
  logic        held_last;
  logic [31:0] cap_data [TOTAL];
  logic        cap_last [TOTAL];

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_clear) begin
        xfer_cnt = 0; word_err = 0; stall_err = 0; stall_seen = 0;
        done_cnt = 0; done_late = 0; last_cyc = -10; held_valid = 1'b0;
      end else begin
        if (out_valid && held_valid &&
            !(out_data == held_data && out_index == held_index && out_last == held_last))
          stall_err++;
        held_valid = out_valid && !out_ready;
        held_data  = out_data;
        held_index = out_index;
        held_last  = out_last;
        if (held_valid) stall_seen++;
        if (out_valid && out_ready) begin
          if (xfer_cnt >= TOTAL || out_data != exp_word(xfer_cnt) ||
              out_index != 32'(xfer_cnt) || out_last != (xfer_cnt == TOTAL-1))
            word_err++;
          if (xfer_cnt < TOTAL) begin
            cap_data[xfer_cnt] = out_data;
            cap_last[xfer_cnt] = out_last;
          end
          if (out_last) last_cyc = cyc;
          xfer_cnt++;
        end
        if (done) begin
          done_cnt++;
          if (cyc != last_cyc + 1) done_late++;
        end
      end
    end
  end

  logic rand_mode = 1'b0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  int n_total = 0, n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, input string name);
    int t = 0;
    while (done_cnt == 0 && t < budget) begin tick(); t++; end
    check({name, "_done_timeout"}, 64'(done_cnt == 0), 64'd0);
    repeat (5) tick();
  endtask

  task automatic begin_sweep();
    mon_clear = 1'b1;
    tick();
    mon_clear = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic sweep_checks(input string name);
    check({name, "_words"},     64'(xfer_cnt),  64'(TOTAL));
    check({name, "_word_err"},  64'(word_err),  64'd0);
    check({name, "_stall_err"}, 64'(stall_err), 64'd0);
    check({name, "_done_cnt"},  64'(done_cnt),  64'd1);
    check({name, "_done_late"}, 64'(done_late), 64'd0);
    check({name, "_busy_after"},64'(busy),      64'd0);
  endtask

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        last;
  } vec_t;
  vec_t vecs [9];

  initial begin
    int n, t;
    vecs[0] = '{0,    32'h0000_0000, 1'b0};
    vecs[1] = '{1,    32'h0000_0001, 1'b0};
    vecs[2] = '{127,  32'h0000_007F, 1'b0};
    vecs[3] = '{128,  32'h0000_0100, 1'b0};
    vecs[4] = '{384,  32'hFFFF_8000, 1'b0};
    vecs[5] = '{385,  32'h0000_7FFF, 1'b0};
    vecs[6] = '{4095, 32'h0000_1F7F, 1'b0};
    vecs[7] = '{4096, 32'h0000_0080, 1'b0};
    vecs[8] = '{8191, 32'h0000_1FFF, 1'b1};

    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 512; a++)
        mem[b][a] = DW'((b << 8) | (a & 8'hFF));
    mem[3][256] = 16'h8000;
    mem[3][257] = 16'h7FFF;

    reset = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_busy",      64'(busy),        64'd0);
    check("rst_done",      64'(done),        64'd0);
    check("rst_out_valid", 64'(out_valid),   64'd0);
    check("rst_rea",       64'(bram_rea),    64'd0);
    check("rst_wea",       64'(bram_wea),    64'd0);
    check("rst_addr_any",  64'(|bram_addra), 64'd0);
`ifdef READOUT_PEAK_EN
    check("rst_peak",      64'(peak_abs),    64'd0);
`endif

    // Sweep 1: full throughput, data pattern with two signed words
    begin_sweep();
    check("s1_busy",      64'(busy),             64'd1);
    check("s1_rea",       64'(bram_rea),         64'd1);
    check("s1_addr_b0",   64'(bram_addra[8:0]),  64'd256);
    n = 1;
    while (!out_valid && n < 20) begin tick(); n++; end
    check("s1_first_valid_latency", 64'(n), 64'd3);
    wait_done(20000, "s1");
    sweep_checks("s1");
    for (int i = 0; i < 9; i++) begin
      check($sformatf("vec%0d_data", vecs[i].idx), 64'(cap_data[vecs[i].idx]), 64'(vecs[i].data));
      check($sformatf("vec%0d_last", vecs[i].idx), 64'(cap_last[vecs[i].idx]), 64'(vecs[i].last));
    end

    // Sweep 2: random backpressure
    rand_mode = 1'b1;
    begin_sweep();
    wait_done(60000, "s2");
    sweep_checks("s2");
    check("s2_stalls_seen", 64'(stall_seen > 100), 64'd1);
    rand_mode = 1'b0;
    tick();

    // Reset mid-sweep at index 1000
    begin_sweep();
    t = 0;
    while (xfer_cnt < 1000 && t < 5000) begin tick(); t++; end
    check("rst_mid_reached", 64'(xfer_cnt >= 1000), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_busy",      64'(busy),      64'd0);
    check("rst_mid_rea",       64'(bram_rea),  64'd0);
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    repeat (20) tick();
    check("rst_mid_no_done",   64'(done_cnt),  64'd0);

    // Restart from index 0, with a stray start at index 500
    begin_sweep();
    check("rs_rea",     64'(bram_rea),        64'd1);
    check("rs_addr_b0", 64'(bram_addra[8:0]), 64'd256);
    t = 0;
    while (xfer_cnt < 500 && t < 5000) begin tick(); t++; end
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rs_busy_after_stray_start", 64'(busy), 64'd1);
    wait_done(20000, "rs");
    sweep_checks("rs");
    check("rs_idx0", 64'(cap_data[0]), 64'h0);

`ifdef READOUT_PEAK_EN
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 512; a++)
        mem[b][a] = DW'(a & 4'hF);
    mem[5][300] = 16'h8000;
    begin_sweep();
    wait_done(20000, "pk");
    check("pk_word_err", 64'(word_err), 64'd0);
    check("pk_peak",     64'(peak_abs), 64'h7FFF);
    begin_sweep();
    check("pk_cleared",  64'(peak_abs), 64'h0);
    wait_done(20000, "pk2");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
